div_iter: RTL

//  Multi-cycle radix-2 restoring integer divider. Produces quotient and remainder for

---
 rtl/div_pkg.sv | 9 +
 rtl/div_step.sv | 24 ++
 rtl/div_iter.sv | 117 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, then subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  // Partial remainder stays below dvs, so the shifted value fits in WIDTH+1 bits
  // and the top bit of the difference is a clean borrow flag.
  always_comb begin
    shl     = {rem, din};
    diff    = shl - {1'b0, dvs};
    q_bit   = ~diff[WIDTH];
    rem_nxt = q_bit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, valid/ready on both sides.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips CALC and goes straight to DONE.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dq, dvs;
  logic             q_sign, r_sign;

  logic             accept, last, div_zero;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, rem_nxt, q_fin;
  logic             q_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign last      = (state == CALC) && (cnt == CW'(WIDTH-1));
  assign div_zero  = (divisor == '0);
  assign dvd_abs   = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_abs   = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // dq holds the dividend bits still to be consumed and collects quotient bits from the bottom
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .din     (dq[WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign q_fin = {dq[WIDTH-2:0], q_bit};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = div_zero ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      rem       <= '0;
      dq        <= '0;
      dvs       <= '0;
      q_sign    <= 1'b0;
      r_sign    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt <= '0;
      rem <= '0;
      // With a zero divisor every step subtracts nothing: quotient ends all ones and the
      // remainder collects the raw dividend, so skip abs and sign fix-up entirely.
      if (div_zero) begin
        dq     <= dividend;
        dvs    <= '0;
        q_sign <= 1'b0;
        r_sign <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
        quotient  <= '1;
        remainder <= dividend;
`endif
      end else begin
        dq     <= dvd_abs;
        dvs    <= dvs_abs;
        q_sign <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_sign <= in_signed & dividend[WIDTH-1];
      end
    end else if (state == CALC && !flush) begin
      cnt <= cnt + 1'b1;
      rem <= rem_nxt;
      dq  <= q_fin;
      if (last) begin
        quotient  <= q_sign ? -q_fin   : q_fin;
        remainder <= r_sign ? -rem_nxt : rem_nxt;
      end
    end
  end

endmodule
